// File: rtl/bus_xcvr_sync.sv
// -----------------------------------------------------------------------------
// bus_xcvr_sync
//
// Clocked, parametrised replacement for a '640/'645-style octal bus
// transceiver. A WIDTH-bit word is moved between bus side A and bus side B
// through registered paths. The pads are split into in/out/oe so the FPGA
// tristate wrappers own the actual bidirectional pins.
//
// Direction changes always pass through a TURN state that holds both output
// enables low for exactly TURN_CYCLES cycles. This gives the shared backplane
// data lines a guaranteed dead band between two drive periods, so the two
// sides never drive against each other.
//
// Parameters
//   WIDTH        data bits per side
//   INVERT       1: out = ~in (LS640 polarity), 0: out = in (LS645 polarity)
//   TURN_CYCLES  dead cycles on every drive exit, legal range 1..15
//
// Ports
//   clk        in   1      system clock, all state changes on rising edge
//   reset      in   1      synchronous, active-high reset
//   cs_n       in   1      chip select, active low; 1 requests idle
//   dir        in   1      1: A->B (drive B), 0: B->A (drive A)
//   hold       in   1      1: freeze the output register currently driven
//   a_in       in   WIDTH  sampled value of bus A
//   a_out      out  WIDTH  value driven onto bus A
//   a_oe       out  1      enable for the bus-A tristate driver
//   b_in       in   WIDTH  sampled value of bus B
//   b_out      out  WIDTH  value driven onto bus B
//   b_oe       out  1      enable for the bus-B tristate driver
//   busy       out  1      1 while in TURN
//   fsm_state  out  2      current FSM state (debug visibility)
//                          0 IDLE, 1 DRV_AB, 2 DRV_BA, 3 TURN
//
// Every output is a flop; there is no combinational path from any input to
// any output.
// -----------------------------------------------------------------------------
module bus_xcvr_sync #(
  parameter int WIDTH       = 8,
  parameter int INVERT      = 1,
  parameter int TURN_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cs_n,
  input  logic             dir,
  input  logic             hold,
  input  logic [WIDTH-1:0] a_in,
  output logic [WIDTH-1:0] a_out,
  output logic             a_oe,
  input  logic [WIDTH-1:0] b_in,
  output logic [WIDTH-1:0] b_out,
  output logic             b_oe,
  output logic             busy,
  output logic [1:0]       fsm_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRV_AB = 2'd1,
    DRV_BA = 2'd2,
    TURN   = 2'd3
  } state_t;

  // Turn counter is 4 bits wide, which is where the 1..15 limit comes from.
  localparam logic [3:0] TURN_LOAD = 4'(TURN_CYCLES);

  state_t     state;
  logic [3:0] turn_cnt;

  // Optional data inversion applied on the way through either path.
  function automatic logic [WIDTH-1:0] xf(input logic [WIDTH-1:0] x);
    return (INVERT != 0) ? ~x : x;
  endfunction

  assign fsm_state = state;

  // ---------------------------------------------------------------------------
  // Single FSM process. Output enables, output data and busy are all updated
  // here so that they change on the same edge as the state they belong to.
  //
  // Notes on the less obvious points:
  //  - Entering a drive state loads the first data word on the same edge as
  //    the oe rises, and ignores hold: hold only freezes a register that is
  //    already driving, it never lets stale data out on the first cycle.
  //  - Leaving a drive state only drops the oe; the data register keeps its
  //    last value.
  //  - cs_n going high and dir flipping in the same cycle take the same
  //    single branch into TURN, so the dead band is never doubled.
  //  - TURN ignores cs_n/dir until its last cycle (counter == 1) and then
  //    decides where to go from the values sampled on that cycle.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      turn_cnt <= 4'd0;
      a_oe     <= 1'b0;
      b_oe     <= 1'b0;
      a_out    <= '0;
      b_out    <= '0;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // Nothing was driving, so a request may start immediately.
          if (!cs_n) begin
            if (dir) begin
              state <= DRV_AB;
              b_oe  <= 1'b1;
              b_out <= xf(a_in);
            end else begin
              state <= DRV_BA;
              a_oe  <= 1'b1;
              a_out <= xf(b_in);
            end
          end
        end

        DRV_AB: begin
          if (cs_n || !dir) begin
            state    <= TURN;
            b_oe     <= 1'b0;
            busy     <= 1'b1;
            turn_cnt <= TURN_LOAD;
          end else if (!hold) begin
            b_out <= xf(a_in);
          end
        end

        DRV_BA: begin
          if (cs_n || dir) begin
            state    <= TURN;
            a_oe     <= 1'b0;
            busy     <= 1'b1;
            turn_cnt <= TURN_LOAD;
          end else if (!hold) begin
            a_out <= xf(b_in);
          end
        end

        TURN: begin
          // The "<=" also covers a zero count, so a bad load can never
          // trap the FSM in TURN.
          if (turn_cnt <= 4'd1) begin
            turn_cnt <= 4'd0;
            busy     <= 1'b0;
            if (cs_n) begin
              state <= IDLE;
            end else if (dir) begin
              state <= DRV_AB;
              b_oe  <= 1'b1;
              b_out <= xf(a_in);
            end else begin
              state <= DRV_BA;
              a_oe  <= 1'b1;
              a_out <= xf(b_in);
            end
          end else begin
            turn_cnt <= turn_cnt - 4'd1;
          end
        end

        default: begin
          state    <= IDLE;
          turn_cnt <= 4'd0;
          a_oe     <= 1'b0;
          b_oe     <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Simulation-only checks (ignored by synthesis).
  // ---------------------------------------------------------------------------
  // The dead-band length must fit the 4-bit counter and be at least one cycle.
  a_turn_range : assert property (@(posedge clk)
    (TURN_CYCLES >= 1) && (TURN_CYCLES <= 15));

  // Both sides must never be enabled at once.
  a_no_contention : assert property (@(posedge clk) !(a_oe && b_oe));

  // busy is exactly "in TURN" outside of reset.
  a_busy_tracks_turn : assert property (@(posedge clk) disable iff (reset)
    busy == (state == TURN));

endmodule

// File: tb/tb_bus_xcvr_sync.sv
// -----------------------------------------------------------------------------
// tb_bus_xcvr_sync
//
// Directed vectors drive the INVERT=1 transceiver; each vector carries the
// hand-computed outputs expected after its clock edge. The driver pushes that
// expectation into exp_q right after the edge, and an independent monitor
// pops and compares on the following falling edge. A second instance built
// with INVERT=0 shares the same inputs for the non-inverting polarity check.
// A random phase then watches for contention and short dead bands.
// -----------------------------------------------------------------------------
module tb_bus_xcvr_sync;

  localparam int TC = 2;
  localparam int EW = 19;  // {a_oe, b_oe, busy, a_out[7:0], b_out[7:0]}

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic       cs_n = 1'b1;
  logic       dir  = 1'b0;
  logic       hold = 1'b0;
  logic [7:0] a_in = 8'h00;
  logic [7:0] b_in = 8'h00;

  logic [7:0] a_out, b_out;
  logic       a_oe, b_oe, busy;
  logic [1:0] fsm_state;

  logic [7:0] a_out0, b_out0;
  logic       a_oe0, b_oe0, busy0;
  logic [1:0] fsm_state0;

  bus_xcvr_sync #(.WIDTH(8), .INVERT(1), .TURN_CYCLES(TC)) u_dut (
    .clk(clk), .reset(reset), .cs_n(cs_n), .dir(dir), .hold(hold),
    .a_in(a_in), .a_out(a_out), .a_oe(a_oe),
    .b_in(b_in), .b_out(b_out), .b_oe(b_oe),
    .busy(busy), .fsm_state(fsm_state)
  );

  bus_xcvr_sync #(.WIDTH(8), .INVERT(0), .TURN_CYCLES(TC)) u_dut0 (
    .clk(clk), .reset(reset), .cs_n(cs_n), .dir(dir), .hold(hold),
    .a_in(a_in), .a_out(a_out0), .a_oe(a_oe0),
    .b_in(b_in), .b_out(b_out0), .b_oe(b_oe0),
    .busy(busy0), .fsm_state(fsm_state0)
  );

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  string         name_q[$];
  int            n_cmp = 0;
  int            n_err = 0;
  bit            rnd_on = 1'b0;
  bit            done   = 1'b0;

  function automatic logic [EW-1:0] pk(input logic aoe, input logic boe,
                                       input logic bsy, input logic [7:0] ao,
                                       input logic [7:0] bo);
    return {aoe, boe, bsy, ao, bo};
  endfunction

  // ---------------- driver ----------------
  // Apply one vector, let one rising edge pass, queue its expected outputs.
  task automatic step(input logic r, input logic c, input logic d,
                      input logic h, input logic [7:0] a, input logic [7:0] b,
                      input logic [EW-1:0] e, input string nm);
    reset = r;
    cs_n  = c;
    dir   = d;
    hold  = h;
    a_in  = a;
    b_in  = b;
    @(posedge clk);
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(negedge clk);
  endtask

  // ---------------- monitor: directed scoreboard ----------------
  always @(negedge clk) begin : mon_sb
    logic [EW-1:0] got;
    logic [EW-1:0] e;
    string         nm;
    if (exp_q.size() > 0) begin
      got = pk(a_oe, b_oe, busy, a_out, b_out);
      e   = exp_q.pop_front();
      nm  = name_q.pop_front();
      n_cmp++;
      if (got !== e) begin
        n_err++;
        $display("FAIL %s: got {a_oe,b_oe,busy,a_out,b_out}=%b,%b,%b,%h,%h required %b,%b,%b,%h,%h",
                 nm, got[18], got[17], got[16], got[15:8], got[7:0],
                 e[18], e[17], e[16], e[15:8], e[7:0]);
      end
    end
  end

  // ---------------- monitor: contention / dead band ----------------
  bit prev_on = 1'b0;
  bit armed   = 1'b0;
  int off_cnt = 0;
  int n_on    = 0;

  always @(negedge clk) begin : mon_turn
    bit on;
    if (rnd_on) begin
      on = a_oe | b_oe;
      n_cmp++;
      if (a_oe && b_oe) begin
        n_err++;
        $display("FAIL contention: a_oe=%b b_oe=%b required not both 1", a_oe, b_oe);
      end
      if (!on) begin
        off_cnt++;
      end else begin
        if (!prev_on && armed) begin
          n_cmp++;
          n_on++;
          if (off_cnt < TC) begin
            n_err++;
            $display("FAIL dead_band: got %0d off cycles required >= %0d", off_cnt, TC);
          end
        end
        off_cnt = 0;
        armed   = 1'b1;
      end
      prev_on = on;
    end
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    // Reset held two cycles with a pending A->B request.
    step(1, 0, 1, 0, 8'h5A, 8'h00, pk(0, 0, 0, 8'h00, 8'h00), "reset_1");
    step(1, 0, 1, 0, 8'h5A, 8'h00, pk(0, 0, 0, 8'h00, 8'h00), "reset_2");
    // A->B drive, inverted.
    step(0, 0, 1, 0, 8'h5A, 8'h00, pk(0, 1, 0, 8'h00, 8'hA5), "ab_first");
    step(0, 0, 1, 0, 8'h00, 8'h00, pk(0, 1, 0, 8'h00, 8'hFF), "ab_data");
    // Direction flip: two dead cycles, then B->A.
    step(0, 0, 0, 0, 8'h00, 8'h0F, pk(0, 0, 1, 8'h00, 8'hFF), "turn_1");
    step(0, 0, 0, 0, 8'h00, 8'h0F, pk(0, 0, 1, 8'h00, 8'hFF), "turn_2");
    step(0, 0, 0, 0, 8'h00, 8'h0F, pk(1, 0, 0, 8'hF0, 8'hFF), "ba_first");
    step(0, 0, 0, 0, 8'h00, 8'hC3, pk(1, 0, 0, 8'h3C, 8'hFF), "ba_data");
    // Hold freezes a_out while b_in changes.
    step(0, 0, 0, 1, 8'h00, 8'h00, pk(1, 0, 0, 8'h3C, 8'hFF), "hold_1");
    step(0, 0, 0, 1, 8'h00, 8'h00, pk(1, 0, 0, 8'h3C, 8'hFF), "hold_2");
    step(0, 0, 0, 1, 8'h00, 8'h00, pk(1, 0, 0, 8'h3C, 8'hFF), "hold_3");
    step(0, 0, 0, 0, 8'h00, 8'h00, pk(1, 0, 0, 8'hFF, 8'hFF), "hold_release");
    // Deselect, then reset during the first TURN cycle.
    step(0, 1, 0, 0, 8'h00, 8'h00, pk(0, 0, 1, 8'hFF, 8'hFF), "desel_turn");
    step(1, 0, 1, 0, 8'h00, 8'h00, pk(0, 0, 0, 8'h00, 8'h00), "reset_mid_turn");
    step(0, 1, 1, 0, 8'h00, 8'h00, pk(0, 0, 0, 8'h00, 8'h00), "idle");
    step(0, 1, 0, 0, 8'h00, 8'h00, pk(0, 0, 0, 8'h00, 8'h00), "idle_dir_toggle");
    // Entering a drive state loads data even with hold asserted.
    step(0, 0, 0, 1, 8'h00, 8'h55, pk(1, 0, 0, 8'hAA, 8'h00), "entry_with_hold");
    // Deselect and dir flip together: a single TURN of TC cycles.
    step(0, 1, 1, 0, 8'h00, 8'h55, pk(0, 0, 1, 8'hAA, 8'h00), "both_exit");
    step(0, 0, 1, 0, 8'h81, 8'h55, pk(0, 0, 1, 8'hAA, 8'h00), "both_turn_2");
    step(0, 0, 1, 0, 8'h81, 8'h55, pk(0, 1, 0, 8'hAA, 8'h7E), "turn_to_ab");
    // Non-inverting build sees the same vector.
    n_cmp++;
    if (b_out0 !== 8'h81 || b_oe0 !== 1'b1) begin
      n_err++;
      $display("FAIL invert0_ab: got b_oe=%b b_out=%h required 1 81", b_oe0, b_out0);
    end
    // Deselect: TURN to IDLE, data registers keep last values.
    step(0, 1, 1, 0, 8'h81, 8'h55, pk(0, 0, 1, 8'hAA, 8'h7E), "desel_b_1");
    step(0, 1, 1, 0, 8'h81, 8'h55, pk(0, 0, 1, 8'hAA, 8'h7E), "desel_b_2");
    step(0, 1, 1, 0, 8'h81, 8'h55, pk(0, 0, 0, 8'hAA, 8'h7E), "idle_kept_data");

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending required 0", exp_q.size());
    end

    // Random phase: contention and dead-band monitor.
    rnd_on = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      cs_n = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 7) == 0) dir = ~dir;
      hold = ($urandom_range(0, 3) == 0);
      a_in = 8'($urandom_range(0, 255));
      b_in = 8'($urandom_range(0, 255));
      @(negedge clk);
    end
    rnd_on = 1'b0;
    n_cmp++;
    if (n_on == 0) begin
      n_err++;
      $display("FAIL random_activity: got %0d drive starts required > 0", n_on);
    end

    done = 1'b1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Watchdog so the run always ends on its own.
  initial begin : watchdog
    #1000000;
    if (!done) begin
      n_err++;
      $display("FAIL watchdog: simulation did not complete in time");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
    end
  end

endmodule
